// File: rtl/cpu_pkg.sv
// Shared constants, fetch-state encoding and IF/ID payload for the 24-bit core.
package cpu_pkg;

  localparam int unsigned XLEN  = 24;
  localparam int unsigned IMM_W = 18;
  localparam int unsigned OPC_W = 6;

  localparam logic [OPC_W-1:0] OPC_HALT     = 6'h3F;
  localparam logic [XLEN-1:0]  RESET_PC_DEF = 24'h000000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_STALL = 2'd2,
    S_HALT  = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } if_id_t;

  // Opcode field of an instruction word
  function automatic logic [OPC_W-1:0] opcode_of(input logic [XLEN-1:0] instr);
    return instr[XLEN-1 -: OPC_W];
  endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry holding buffer that catches a fetch returning while decode is stalled.
module fetch_skid
  import cpu_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   load,
  input  logic   drain,
  input  logic   clear,
  input  if_id_t din,
  output logic   valid,
  output if_id_t data
);

  // Clear (redirect) wins over load; drain empties after the entry moves on
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= din;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, imem req/ack handshake, IF/ID slot, skid, redirect and HALT.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [XLEN-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [XLEN-1:0]   imem_rdata,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_target,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [XLEN-1:0]   id_instr,
  output logic [XLEN-1:0]   id_pc,
  output logic [OPC_W-1:0]  id_opcode,
  output logic [IMM_W-1:0]  id_imm18,
  output logic              halted
);

  fetch_state_e    state;
  fetch_state_e    next_state;
  logic [XLEN-1:0] pc;
  logic            squash;

  logic            skid_valid;
  if_id_t          skid_data;
  if_id_t          fetched;

  logic            consume;
  logic            slot_free;
  logic            ack_take;
  logic            fetch_ok;
  logic            fetch_halt;

  logic            slot_load;
  logic            slot_from_skid;
  logic            slot_clear;
  logic            skid_load;
  logic            skid_drain;
  logic            skid_clear;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] addr_d;
  logic            squash_d;

  assign consume    = id_valid && id_ready;
  assign slot_free  = !id_valid || id_ready;
  assign ack_take   = (state == S_REQ) && imem_req && imem_ack;
  assign fetch_ok   = ack_take && !squash && !redirect_valid;
  assign fetched    = '{instr: imem_rdata, pc: imem_addr};
  assign fetch_halt = (opcode_of(imem_rdata) == OPC_HALT);

  // The slot fields are straight slices of the registered instruction
  assign id_opcode = id_instr[XLEN-1 -: OPC_W];
  assign id_imm18  = id_instr[IMM_W-1:0];

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Next-state: redirect overrides everything, a full skid parks the FSM in S_STALL
  always_comb begin
    next_state = state;
    if (redirect_valid) begin
      next_state = S_REQ;
    end else begin
      case (state)
        S_IDLE:  next_state = S_REQ;
        S_REQ: begin
          if (fetch_ok) begin
            if (!slot_free)      next_state = S_STALL;
            else if (fetch_halt) next_state = S_HALT;
          end
        end
        S_STALL: begin
          if (consume && skid_valid)
            next_state = (opcode_of(skid_data.instr) == OPC_HALT) ? S_HALT : S_REQ;
        end
        S_HALT:  next_state = S_HALT;
        default: next_state = S_IDLE;
      endcase
    end
  end

  // Datapath controls: slot/skid moves, PC and request address, squash bookkeeping
  always_comb begin
    slot_load      = 1'b0;
    slot_from_skid = 1'b0;
    slot_clear     = 1'b0;
    skid_load      = 1'b0;
    skid_drain     = 1'b0;
    skid_clear     = 1'b0;
    pc_d           = pc;
    addr_d         = imem_addr;
    squash_d       = squash;
    if (redirect_valid) begin
      slot_clear = 1'b1;
      skid_clear = 1'b1;
      pc_d       = redirect_target;
      if ((state == S_REQ) && imem_req && !imem_ack) begin
        // Request in flight: keep it stable and drop its data when it returns
        squash_d = 1'b1;
      end else begin
        squash_d = 1'b0;
        addr_d   = redirect_target;
      end
    end else begin
      if (consume) slot_clear = 1'b1;
      case (state)
        S_REQ: begin
          if (ack_take) begin
            if (squash) begin
              squash_d = 1'b0;
              addr_d   = pc;
            end else begin
              if (slot_free) slot_load = 1'b1;
              else           skid_load = 1'b1;
              pc_d   = pc + XLEN'(1);
              addr_d = pc + XLEN'(1);
            end
          end
        end
        S_STALL: begin
          if (consume && skid_valid) begin
            slot_from_skid = 1'b1;
            skid_drain     = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Registered PC, request port, status and IF/ID slot
  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= RESET_PC;
      imem_addr <= RESET_PC;
      imem_req  <= 1'b0;
      squash    <= 1'b0;
      halted    <= 1'b0;
      id_valid  <= 1'b0;
      id_instr  <= '0;
      id_pc     <= '0;
    end else begin
      pc        <= pc_d;
      imem_addr <= addr_d;
      squash    <= squash_d;
      imem_req  <= (next_state == S_REQ);
      halted    <= (next_state == S_HALT);
      if (slot_load) begin
        id_valid <= 1'b1;
        id_instr <= fetched.instr;
        id_pc    <= fetched.pc;
      end else if (slot_from_skid) begin
        id_valid <= 1'b1;
        id_instr <= skid_data.instr;
        id_pc    <= skid_data.pc;
      end else if (slot_clear) begin
        id_valid <= 1'b0;
      end
    end
  end

  fetch_skid u_skid (
    .clk   (clk),
    .rst   (rst),
    .load  (skid_load),
    .drain (skid_drain),
    .clear (skid_clear),
    .din   (fetched),
    .valid (skid_valid),
    .data  (skid_data)
  );

endmodule
